sysid_checker: RTL and testbench
================================

Name: sysid_checker

Overview:
- Avalon-MM master that reads a system-ID slave and confirms the hardware matches the software build.
- After a start pulse it reads word 0 (ID) and then word 1 (build timestamp) from the slave's control port, and compares both against parameters.
- Reports pass/fail plus the captured values. Sits beside the CPU and drives the sysid control slave, either directly or through the interconnect, as a boot-time integrity check.

Parameters:
- EXPECTED_ID, 32'd0: value required at address 0.
- EXPECTED_TIMESTAMP, 32'd1365705896: value required at address 1.
- TIMEOUT_CYCLES, 255: maximum consecutive waitrequest-high cycles per read before abort. Range 1..65535; the counter is 16 bits.
- RETRY_LIMIT, 3: extra attempts allowed on mismatch. Used only with the optional feature; range 0..15.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a check.
- avm_address  out  1  word address presented to the slave.
- avm_read  out  1  read request.
- avm_readdata  in  32  slave read data.
- avm_waitrequest  in  1  slave stall.
- busy  out  1  high from the accepted start until done.
- done  out  1  high in the DONE state; held until the next accepted start.
- pass  out  1  check result; valid while done=1.
- timeout_err  out  1  abort caused by timeout; valid while done=1.
- id_value  out  32  captured word 0.
- timestamp_value  out  32  captured word 1.

Behaviour:
- Reset values: all outputs 0; state IDLE; timeout counter 0; retry counter 0.
- Reset asserted mid-transfer drops avm_read in the same cycle, asynchronously.
- States: IDLE, RD_ID, RD_TS, COMPARE, DONE.
- IDLE or DONE, start=1 at edge N:
  - Go to RD_ID.
  - Clear done, pass, timeout_err, timeout counter and retry counter.
  - Set busy.
- In any other state, start is ignored.
- RD_ID: avm_read=1, avm_address=0.
  - Transfer completes on an edge where avm_read=1 and avm_waitrequest=0.
  - On completion, capture avm_readdata into id_value and go to RD_TS.
- RD_TS: the same rules with avm_address=1; capture into timestamp_value; go to COMPARE.
- avm_address and avm_read stay stable while waitrequest=1 (Avalon master rule).
- avm_read is 0 in IDLE, COMPARE and DONE.
- Timeout:
  - The counter increments on each edge in RD_ID or RD_TS where waitrequest=1.
  - It resets to 0 on each completed transfer.
  - When it would reach TIMEOUT_CYCLES: deassert avm_read, go to DONE with timeout_err=1 and pass=0.
  - The captured value for the incomplete read keeps its previous content.
- COMPARE (one cycle): pass = (id_value==EXPECTED_ID) && (timestamp_value==EXPECTED_TIMESTAMP). Go to DONE; busy=0, done=1.
- Latency with waitrequest held 0: start sampled at edge N; reads are in cycles N+1 and N+2; COMPARE in N+3; done=1 after edge N+3.
- Comparison is full 32-bit, unsigned and exact.

Optional Feature:
- Macro: SYSID_CHECK_RETRY_EN.
- Defined:
  - If COMPARE fails and the retry counter < RETRY_LIMIT, increment the counter and return to RD_ID instead of DONE.
  - Each retry adds 2 reads + 1 COMPARE cycle.
  - Timeouts are never retried.
  - A retry_count output [3:0] is added, reset 0, holding the attempts used.
- Undefined: COMPARE always goes to DONE; no retry counter or port exists.

Test Plan:
- Zero-wait slave returning 0 then 1365705896; pulse start -> address 0 then 1 on consecutive cycles; done=1 and pass=1 three cycles after the start edge; id_value=0; timestamp_value=1365705896.
- Slave returns 1365705897 at address 1 -> done=1, pass=0, timeout_err=0, timestamp_value=1365705897.
- waitrequest held high 2 cycles on each read -> avm_read and avm_address stable during the stalls; pass=1; done 7 cycles after start.
- waitrequest stuck high with TIMEOUT_CYCLES=4 -> avm_read drops; done=1, timeout_err=1, pass=0; no further reads.
- start pulsed during RD_TS, then reset asserted mid-RD_TS -> the start is ignored; all outputs go to 0 immediately; a new start runs a clean check.
- With SYSID_CHECK_RETRY_EN, RETRY_LIMIT=2, mismatch on the first read pair then a match -> retry_count=1, pass=1. With a persistent mismatch -> retry_count=2, pass=0 after 3 attempts.

Source files
------------

// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM master that reads the system-ID slave at boot.
// It fetches word 0 (ID) and word 1 (build timestamp), compares both against
// the expected build values and reports pass/fail with the captured words.
// Optional feature macro: SYSID_CHECK_RETRY_EN. When defined, a failed
// comparison re-reads both words up to RETRY_LIMIT more times, and a
// retry_count port exposes how many retries were used.

module sysid_checker #(
   parameter logic [31:0] EXPECTED_ID        = 32'd0,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1365705896,
   parameter int          TIMEOUT_CYCLES     = 255,
   parameter int          RETRY_LIMIT        = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        timeout_err,
   output logic [31:0] id_value,
   output logic [31:0] timestamp_value
`ifdef SYSID_CHECK_RETRY_EN
   ,
   output logic [3:0]  retry_count
`endif
);

   // Reject parameter values the 16-bit timeout and 4-bit retry counters cannot hold
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535 || RETRY_LIMIT < 0 || RETRY_LIMIT > 15) begin : g_paramRange
      $error("sysid_checker: TIMEOUT_CYCLES or RETRY_LIMIT out of range");
   end

   typedef enum logic [2:0] {
      IDLE,
      RD_ID,
      RD_TS,
      COMPARE,
      DONE
   } state_t;

   // The abort fires on the stall edge that would bring the counter up to TIMEOUT_CYCLES
   localparam logic [15:0] TOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      r_state;
   state_t      w_nextState;
   logic [15:0] r_toutCnt;
   logic        w_reading;
   logic        w_xferDone;
   logic        w_timeout;
   logic        w_startOk;
   logic        w_match;
   logic        w_retry;

   assign w_reading  = (r_state == RD_ID) || (r_state == RD_TS);
   assign w_xferDone = w_reading && !avm_waitrequest;
   assign w_timeout  = w_reading && avm_waitrequest && (r_toutCnt == TOUT_LAST);
   assign w_startOk  = start && ((r_state == IDLE) || (r_state == DONE));
   assign w_match    = (id_value == EXPECTED_ID) && (timestamp_value == EXPECTED_TIMESTAMP);

`ifdef SYSID_CHECK_RETRY_EN
   localparam logic [3:0] RETRY_MAX = 4'(RETRY_LIMIT);

   logic [3:0] r_retryCnt;

   assign w_retry     = !w_match && (r_retryCnt < RETRY_MAX);
   assign retry_count = r_retryCnt;

   // Count retries used in this check; a new accepted start clears the count
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_retryCnt <= 4'd0;
      end else if (w_startOk) begin
         r_retryCnt <= 4'd0;
      end else if ((r_state == COMPARE) && w_retry) begin
         r_retryCnt <= r_retryCnt + 4'd1;
      end
   end
`else
   assign w_retry = 1'b0;
`endif

   // Bus and status outputs decode straight from the state so reset drops them asynchronously
   assign avm_read    = w_reading;
   assign avm_address = (r_state == RD_TS);
   assign busy        = w_reading || (r_state == COMPARE);
   assign done        = (r_state == DONE);

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: two reads, one compare cycle, then park in DONE until restarted
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE, DONE: begin
            if (start) begin
               w_nextState = RD_ID;
            end
         end
         RD_ID: begin
            if (w_timeout) begin
               w_nextState = DONE;
            end else if (w_xferDone) begin
               w_nextState = RD_TS;
            end
         end
         RD_TS: begin
            if (w_timeout) begin
               w_nextState = DONE;
            end else if (w_xferDone) begin
               w_nextState = COMPARE;
            end
         end
         COMPARE: begin
            w_nextState = w_retry ? RD_ID : DONE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Consecutive stall counter; any completed transfer or new start restarts it
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_toutCnt <= 16'd0;
      end else if (w_startOk || w_xferDone) begin
         r_toutCnt <= 16'd0;
      end else if (w_reading && avm_waitrequest) begin
         r_toutCnt <= r_toutCnt + 16'd1;
      end
   end

   // Capture read data only on a completed transfer so an aborted read leaves the old word
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         id_value        <= 32'd0;
         timestamp_value <= 32'd0;
      end else if (w_xferDone) begin
         if (r_state == RD_ID) begin
            id_value <= avm_readdata;
         end else begin
            timestamp_value <= avm_readdata;
         end
      end
   end

   // Result flags: cleared by an accepted start, set by the compare cycle or a timeout abort
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pass        <= 1'b0;
         timeout_err <= 1'b0;
      end else if (w_startOk) begin
         pass        <= 1'b0;
         timeout_err <= 1'b0;
      end else if (w_timeout) begin
         pass        <= 1'b0;
         timeout_err <= 1'b1;
      end else if (r_state == COMPARE) begin
         pass <= w_match;
      end
   end

endmodule

// File: tb/tb_sysid_checker.sv
// tb_sysid_checker: directed test of sysid_checker against a behavioural
// sysid slave. The driver pushes the expected result of each check into a
// scoreboard queue; a monitor pops and compares whenever done rises.

module tb_sysid_checker;

   localparam logic [31:0] GOOD_ID = 32'd0;
   localparam logic [31:0] GOOD_TS = 32'd1365705896;
   localparam logic [31:0] BAD_TS  = 32'd1365705897;

`ifdef SYSID_CHECK_RETRY_EN
   localparam int MISS_LAT   = 9;
   localparam int MISS_RETRY = 2;
`else
   localparam int MISS_LAT   = 3;
   localparam int MISS_RETRY = 0;
`endif

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        avm_address;
   logic        avm_read;
   logic [31:0] avm_readdata;
   logic        avm_waitrequest;
   logic        busy;
   logic        done;
   logic        pass;
   logic        timeout_err;
   logic [31:0] id_value;
   logic [31:0] timestamp_value;
`ifdef SYSID_CHECK_RETRY_EN
   logic [3:0]  retry_count;
`endif

   int checks = 0;
   int errors = 0;
   int cycCnt = 0;

   // Slave model controls
   logic [31:0] slvId;
   logic [31:0] slvTs;
   int          badTsReads;
   int          tsBase;
   int          tsReadsDone;
   int          stallCycles;
   int          stallCnt;
   bit          stuckTs;

   // Transfer log and stall-stability monitor
   int          logAddr[$];
   int          logCyc[$];
   bit          checkStable;
   int          stableViol;
   logic        prevStallRead;
   logic        prevAddr;
   logic        prevDone;

   typedef struct {
      string       name;
      logic [31:0] expPass;
      logic [31:0] expTerr;
      logic [31:0] expId;
      logic [31:0] expTs;
      int          expLat;
      int          expRetry;
      int          startStamp;
   } exp_t;

   exp_t sbQ[$];
   exp_t monItem;

   sysid_checker #(
      .TIMEOUT_CYCLES(4),
      .RETRY_LIMIT   (2)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .avm_address    (avm_address),
      .avm_read       (avm_read),
      .avm_readdata   (avm_readdata),
      .avm_waitrequest(avm_waitrequest),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .timeout_err    (timeout_err),
      .id_value       (id_value),
      .timestamp_value(timestamp_value)
`ifdef SYSID_CHECK_RETRY_EN
      ,
      .retry_count    (retry_count)
`endif
   );

   always #5 clock = ~clock;

   // Free-running cycle counter used for latency measurement
   always @(posedge clock) cycCnt <= cycCnt + 1;

   // Slave: stalls each read for stallCycles, or forever on address 1 when stuckTs is set
   assign avm_waitrequest = avm_read && ((stuckTs && avm_address) || (stallCnt < stallCycles));
   assign avm_readdata    = !avm_read ? 32'hDEADBEEF :
                            !avm_address ? slvId :
                            ((tsReadsDone - tsBase) < badTsReads) ? BAD_TS : slvTs;

   // Slave state: stall counter per read and number of completed timestamp reads
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         stallCnt <= 0;
      end else begin
         if (avm_read && avm_waitrequest) stallCnt <= stallCnt + 1;
         else stallCnt <= 0;
         if (avm_read && !avm_waitrequest && avm_address) tsReadsDone <= tsReadsDone + 1;
      end
   end

   // Log every transfer that completes at the coming edge
   always @(negedge clock) begin
      if (avm_read && !avm_waitrequest) begin
         logAddr.push_back(int'(avm_address));
         logCyc.push_back(cycCnt);
      end
   end

   // Flag any change of read/address following a stalled cycle
   always @(negedge clock) begin
      if (checkStable && prevStallRead && !(avm_read && (avm_address == prevAddr)))
         stableViol <= stableViol + 1;
      prevStallRead <= avm_read && avm_waitrequest;
      prevAddr      <= avm_address;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, actual, actual, expected, expected);
      end
   endtask

   // Monitor: each rising edge of done retires one scoreboard entry
   always @(negedge clock) begin
      if (done && !prevDone) begin
         if (sbQ.size() == 0) begin
            checkOutput("unexpected_done", 32'd1, 32'd0);
         end else begin
            monItem = sbQ.pop_front();
            checkOutput({monItem.name, "_pass"}, 32'(pass), monItem.expPass);
            checkOutput({monItem.name, "_timeout_err"}, 32'(timeout_err), monItem.expTerr);
            checkOutput({monItem.name, "_id_value"}, id_value, monItem.expId);
            checkOutput({monItem.name, "_timestamp_value"}, timestamp_value, monItem.expTs);
            checkOutput({monItem.name, "_latency"}, 32'(cycCnt - monItem.startStamp - 1), 32'(monItem.expLat));
            checkOutput({monItem.name, "_busy_low"}, 32'(busy), 32'd0);
`ifdef SYSID_CHECK_RETRY_EN
            checkOutput({monItem.name, "_retry_count"}, 32'(retry_count), 32'(monItem.expRetry));
`endif
         end
      end
      prevDone <= done;
   end

   // Pulse start for one edge and queue the expected result of that check
   task automatic applyStimulus(input string name, input logic ePass, input logic eTerr,
                                input logic [31:0] eId, input logic [31:0] eTs,
                                input int eLat, input int eRetry);
      exp_t e;
      @(negedge clock);
      e.name       = name;
      e.expPass    = 32'(ePass);
      e.expTerr    = 32'(eTerr);
      e.expId      = eId;
      e.expTs      = eTs;
      e.expLat     = eLat;
      e.expRetry   = eRetry;
      e.startStamp = cycCnt;
      sbQ.push_back(e);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   // Wait, bounded, until the monitor has retired every queued check
   task automatic waitDone(input string name, input int budget);
      int n;
      n = 0;
      while (sbQ.size() != 0 && n < budget) begin
         @(negedge clock);
         n++;
      end
      @(negedge clock);
      checkOutput({name, "_done_seen"}, 32'(sbQ.size()), 32'd0);
      sbQ.delete();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int base;
      int n;
      int viol0;

      reset       = 1'b1;
      start       = 1'b0;
      slvId       = GOOD_ID;
      slvTs       = GOOD_TS;
      badTsReads  = 0;
      tsBase      = 0;
      tsReadsDone = 0;
      stallCycles = 0;
      stuckTs     = 1'b0;
      checkStable = 1'b0;
      stableViol  = 0;
      prevDone    = 1'b0;

      // Reset state
      repeat (3) @(negedge clock);
      checkOutput("rst_avm_read", 32'(avm_read), 32'd0);
      checkOutput("rst_avm_address", 32'(avm_address), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_pass", 32'(pass), 32'd0);
      checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
      checkOutput("rst_values", id_value | timestamp_value, 32'd0);
`ifdef SYSID_CHECK_RETRY_EN
      checkOutput("rst_retry_count", 32'(retry_count), 32'd0);
`endif
      reset = 1'b0;

      // Zero-wait matching slave: reads on consecutive cycles, done three edges after start
      base = logAddr.size();
      applyStimulus("match", 1'b1, 1'b0, GOOD_ID, GOOD_TS, 3, 0);
      waitDone("match", 30);
      checkOutput("match_xfer_count", 32'(logAddr.size() - base), 32'd2);
      if (logAddr.size() - base == 2) begin
         checkOutput("match_addr0", 32'(logAddr[base]), 32'd0);
         checkOutput("match_addr1", 32'(logAddr[base + 1]), 32'd1);
         checkOutput("match_consecutive", 32'(logCyc[base + 1] - logCyc[base]), 32'd1);
      end

      // Timestamp off by one
      badTsReads = 1000;
      tsBase     = tsReadsDone;
      applyStimulus("ts_miss", 1'b0, 1'b0, GOOD_ID, BAD_TS, MISS_LAT, MISS_RETRY);
      waitDone("ts_miss", 40);
      badTsReads = 0;

      // Wrong ID with correct timestamp
      slvId = 32'h12345678;
      applyStimulus("id_miss", 1'b0, 1'b0, 32'h12345678, GOOD_TS, MISS_LAT, MISS_RETRY);
      waitDone("id_miss", 40);
      slvId = GOOD_ID;

      // Two stall cycles per read: bus held stable, done seven edges after start
      stallCycles = 2;
      viol0       = stableViol;
      checkStable = 1'b1;
      applyStimulus("stall", 1'b1, 1'b0, GOOD_ID, GOOD_TS, 7, 0);
      waitDone("stall", 40);
      checkStable = 1'b0;
      checkOutput("stall_bus_stable", 32'(stableViol - viol0), 32'd0);
      stallCycles = 0;

      // Timestamp read stuck: abort after four stalls, timestamp keeps its old value
      slvId   = 32'hA5A50001;
      slvTs   = 32'h0BAD0BAD;
      stuckTs = 1'b1;
      applyStimulus("timeout", 1'b0, 1'b1, 32'hA5A50001, GOOD_TS, 5, 0);
      waitDone("timeout", 40);
      checkOutput("timeout_read_dropped", 32'(avm_read), 32'd0);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (avm_read) n++;
      end
      checkOutput("timeout_no_more_reads", 32'(n), 32'd0);
      checkOutput("timeout_done_held", 32'(done), 32'd1);
      stuckTs = 1'b0;
      slvId   = GOOD_ID;
      slvTs   = GOOD_TS;

      // Start during RD_TS is ignored; reset mid-RD_TS clears everything at once
      stallCycles = 2;
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      n = 0;
      while (!(avm_read && avm_address) && n < 20) begin
         @(negedge clock);
         n++;
      end
      checkOutput("mid_reached_rd_ts", 32'(avm_read && avm_address), 32'd1);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      checkOutput("mid_start_ignored_addr", 32'(avm_address), 32'd1);
      checkOutput("mid_start_ignored_read", 32'(avm_read), 32'd1);
      checkOutput("mid_busy", 32'(busy), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_rst_avm_read", 32'(avm_read), 32'd0);
      checkOutput("async_rst_avm_address", 32'(avm_address), 32'd0);
      checkOutput("async_rst_busy", 32'(busy), 32'd0);
      checkOutput("async_rst_flags", 32'({done, pass, timeout_err}), 32'd0);
      checkOutput("async_rst_values", id_value | timestamp_value, 32'd0);
      @(negedge clock);
      reset       = 1'b0;
      stallCycles = 0;

      // Clean check after reset
      applyStimulus("post_reset", 1'b1, 1'b0, GOOD_ID, GOOD_TS, 3, 0);
      waitDone("post_reset", 30);

`ifdef SYSID_CHECK_RETRY_EN
      // One mismatching pair then a match: one retry, pass
      badTsReads = 1;
      tsBase     = tsReadsDone;
      applyStimulus("retry_once", 1'b1, 1'b0, GOOD_ID, GOOD_TS, 6, 1);
      waitDone("retry_once", 40);
      badTsReads = 0;
`endif

      repeat (2) @(negedge clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
